// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
//   Round-robin arbiter that shares one synchronous sprite/background ROM
//   between NUM_REQ pixel renderers. At most one grant is issued per cycle.
//   A tag pipeline runs alongside each ROM read, so the returned data comes
//   back to the requester that won, a fixed MEM_LATENCY+1 cycles after its
//   grant.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous, active-high reset
//   i_req        per-requester read request (level)
//   i_req_addr   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   o_gnt        one-hot grant pulse (registered)
//   o_mem_rd     ROM read strobe (registered)
//   o_mem_addr   ROM address (registered, holds when idle)
//   i_mem_rdata  ROM read data, valid MEM_LATENCY cycles after o_mem_rd
//   o_rsp_valid  one-hot response strobe (registered)
//   o_rsp_data   response data (holds when no response)
//   o_oob_err    sticky flag: an out-of-range address was granted
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 8,
   parameter int MEM_DEPTH   = 150016,
   parameter int MEM_LATENCY = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
   output logic [NUM_REQ-1:0]        o_gnt,
   output logic                      o_mem_rd,
   output logic [ADDR_W-1:0]         o_mem_addr,
   input  logic [DATA_W-1:0]         i_mem_rdata,
   output logic [NUM_REQ-1:0]        o_rsp_valid,
   output logic [DATA_W-1:0]         o_rsp_data,
   output logic                      o_oob_err
);

   localparam int PTR_W = $clog2(NUM_REQ);
   // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);

   logic [PTR_W-1:0]   r_ptr;
   logic [NUM_REQ-1:0] r_gnt;
   logic               r_mem_rd;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic               r_gnt_oob;
   logic               r_oob_err;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [DATA_W-1:0]  r_rsp_data;

   // Tag stage j is visible MEM_LATENCY cycles... stage MEM_LATENCY-1 lines
   // up with the ROM data for the read issued MEM_LATENCY cycles earlier.
   logic [NUM_REQ-1:0] r_pipe_gnt [MEM_LATENCY];
   logic               r_pipe_oob [MEM_LATENCY];

   logic [NUM_REQ-1:0] w_mreq;
   logic               w_hi_found;
   logic [PTR_W-1:0]   w_hi_idx;
   logic               w_found;
   logic [PTR_W-1:0]   w_lo_idx;
   logic [PTR_W-1:0]   w_win;
   logic [ADDR_W-1:0]  w_win_addr;
   logic [NUM_REQ-1:0] w_gnt_nxt;
   logic               w_oob;
   logic [PTR_W-1:0]   w_ptr_nxt;

   // A requester being granted this cycle is masked so a held req is not
   // granted twice for the same read.
   assign w_mreq = i_req & ~r_gnt;

   // Round-robin pick: lowest set bit at or above the pointer, otherwise the
   // lowest set bit overall (the wrap-around part of the scan).
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_found    = 1'b0;
      w_lo_idx   = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (w_mreq[i]) begin
            w_found  = 1'b1;
            w_lo_idx = PTR_W'(i);
            if (PTR_W'(i) >= r_ptr) begin
               w_hi_found = 1'b1;
               w_hi_idx   = PTR_W'(i);
            end
         end
      end
      w_win = w_hi_found ? w_hi_idx : w_lo_idx;

      w_win_addr = '0;
      w_gnt_nxt  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_found && (w_win == PTR_W'(i))) begin
            w_win_addr   = i_req_addr[i*ADDR_W +: ADDR_W];
            w_gnt_nxt[i] = 1'b1;
         end
      end

      w_oob     = w_found && ({1'b0, w_win_addr} >= DEPTH_X);
      w_ptr_nxt = (w_win == PTR_W'(NUM_REQ-1)) ? '0 : w_win + PTR_W'(1);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr      <= '0;
         r_gnt      <= '0;
         r_mem_rd   <= 1'b0;
         r_mem_addr <= '0;
         r_gnt_oob  <= 1'b0;
         r_oob_err  <= 1'b0;
      end else begin
         r_gnt     <= w_gnt_nxt;
         r_mem_rd  <= w_found;
         r_gnt_oob <= w_oob;
         if (w_found) begin
            r_ptr      <= w_ptr_nxt;
            r_mem_addr <= w_oob ? '0 : w_win_addr;
         end
         if (w_oob) begin
            r_oob_err <= 1'b1;
         end
      end
   end

   // Clearing the tags on reset is what discards reads already in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int j = 0; j < MEM_LATENCY; j++) begin
            r_pipe_gnt[j] <= '0;
            r_pipe_oob[j] <= 1'b0;
         end
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_pipe_gnt[0] <= r_gnt;
         r_pipe_oob[0] <= r_gnt_oob;
         for (int j = 1; j < MEM_LATENCY; j++) begin
            r_pipe_gnt[j] <= r_pipe_gnt[j-1];
            r_pipe_oob[j] <= r_pipe_oob[j-1];
         end
         r_rsp_valid <= r_pipe_gnt[MEM_LATENCY-1];
         if (|r_pipe_gnt[MEM_LATENCY-1]) begin
            // Out-of-range reads return palette index 0 (transparent).
            r_rsp_data <= r_pipe_oob[MEM_LATENCY-1] ? '0 : i_mem_rdata;
         end
      end
   end

   assign o_gnt       = r_gnt;
   assign o_mem_rd    = r_mem_rd;
   assign o_mem_addr  = r_mem_addr;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
   assign o_oob_err   = r_oob_err;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//   Directed and random stimulus for sprite_rom_arbiter, checked each cycle
//   against a transaction-level reference model (round-robin pick by modulo
//   scan, queue of expected responses with due cycle).
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

   localparam int N       = 4;
   localparam int AW      = 18;
   localparam int DW      = 8;
   localparam int DEPTH   = 150016;
   localparam int LAT     = 2;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    gnt;
   logic            mem_rd;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_rdata;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            oob_err;

   sprite_rom_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_addr(req_addr),
      .o_gnt(gnt), .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
      .i_mem_rdata(mem_rdata), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
      .o_oob_err(oob_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] rom_f(logic [AW-1:0] a);
      return a[7:0] ^ {a[17:16], a[13:8]} ^ 8'h5A;
   endfunction

   // ROM with two cycles of read latency.
   logic [DW-1:0] rom_d1;
   always @(posedge clk) begin
      rom_d1    <= rom_f(mem_addr);
      mem_rdata <= rom_d1;
   end

   typedef struct {
      int            due;
      int            who;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          pend[$];
   int            cyc;
   int            m_ptr;
   logic [N-1:0]  m_gnt;
   logic          m_rd;
   logic [AW-1:0] m_addr;
   logic          m_oob;
   logic [DW-1:0] m_data;

   int n_vec;
   int n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(logic [N-1:0] m, int p);
      for (int off = 0; off < N; off++) begin
         if (m[(p + off) % N]) return (p + off) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      pend.delete();
      m_ptr  = 0;
      m_gnt  = '0;
      m_rd   = 1'b0;
      m_addr = '0;
      m_oob  = 1'b0;
      m_data = '0;
   endtask

   // One clock: predict from current inputs, clock, compare all outputs.
   task automatic step();
      int            w;
      logic [AW-1:0] a;
      logic          oob;
      logic [N-1:0]  exp_rv;
      rsp_t          r;
      w = pick(req & ~m_gnt, m_ptr);
      if (w >= 0) begin
         a      = req_addr[w*AW +: AW];
         oob    = (int'(a) >= DEPTH);
         m_gnt  = N'(1) << w;
         m_rd   = 1'b1;
         m_addr = oob ? '0 : a;
         m_ptr  = (w + 1) % N;
         if (oob) m_oob = 1'b1;
         r.due  = cyc + 1 + LAT + 1;
         r.who  = w;
         r.data = oob ? '0 : rom_f(a);
         pend.push_back(r);
      end else begin
         m_gnt = '0;
         m_rd  = 1'b0;
      end
      @(posedge clk);
      cyc++;
      #1;
      exp_rv = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_rv = N'(1) << pend[0].who;
         m_data = pend[0].data;
         void'(pend.pop_front());
      end
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("mem_rd", 32'(mem_rd), 32'(m_rd));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("oob_err", 32'(oob_err), 32'(m_oob));
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      #3 rst = 1'b1;
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_oob_err", 32'(oob_err), 32'd0);
      #2 rst = 1'b0;
      model_reset();
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   task automatic idle(input int n);
      req = '0;
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int cnt;
      n_vec    = 0;
      n_err    = 0;
      cyc      = 0;
      rst      = 1'b0;
      req      = '0;
      req_addr = '0;
      model_reset();
      #2 rst = 1'b1;
      #10 rst = 1'b0;
      @(posedge clk); #1;
      chk("init_gnt", 32'(gnt), 32'd0);
      chk("init_oob", 32'(oob_err), 32'd0);
      idle(2);

      // Full contention from ptr=0: grants 0,1,2,3,0,... one per cycle.
      for (int i = 0; i < N; i++) set_addr(i, AW'(32'h100 * (i + 1) + i));
      req = 4'b1111;
      for (int k = 0; k < 8; k++) step();
      idle(5);

      // Single request with drop in the grant cycle.
      set_addr(1, 18'h00280);
      req = 4'b0010;
      step();
      chk("t2_gnt", 32'(gnt), 32'h2);
      idle(5);

      // Held single request: granted on alternate cycles.
      set_addr(2, 18'h01234);
      req = 4'b0100;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (gnt[2]) cnt++;
      end
      chk("t4_count", 32'(cnt), 32'd5);
      idle(5);

      // Out-of-range address: mem_addr 0, sticky error, zero response data.
      set_addr(0, 18'h3FFFF);
      req = 4'b0001;
      step();
      req = '0;
      idle(6);
      chk("t5_sticky", 32'(oob_err), 32'd1);

      // Reset one cycle after a grant: response discarded, ptr back to 0.
      set_addr(2, 18'h00010);
      req = 4'b0100;
      step();
      req = '0;
      step();
      pulse_reset();
      idle(4);
      set_addr(1, 18'h00456);
      set_addr(3, 18'h00789);
      req = 4'b1010;
      step();
      chk("t6_ptr0", 32'(gnt), 32'h2);
      idle(5);

      // Random traffic with a mid-stream reset.
      for (int k = 0; k < 300; k++) begin
         req = N'($urandom_range(0, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0)
               set_addr(i, AW'($urandom_range(DEPTH, (1 << AW) - 1)));
            else
               set_addr(i, AW'($urandom_range(0, DEPTH - 1)));
         end
         step();
         if (k == 150) begin
            req = '0;
            pulse_reset();
         end
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
